// File: rtl/arm_pkg.sv
// Shared types for the store buffer: entry layout, doubleword offset and flush FSM states.
package arm_pkg;
  localparam int N         = 64;
  localparam int DW_OFFSET = 3;
  localparam int TAG_W     = N - DW_OFFSET;

  typedef struct packed {
    logic [N-4:0] tag;
    logic [N-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE,
    SB_FLUSH
  } sb_state_e;
endpackage

// File: rtl/store_buffer_if.sv
// Core-side and dmem-side signals of the store buffer; slave is the buffer, master its environment.
interface store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [arm_pkg::N-1:0] DM_addr;
  logic [arm_pkg::N-1:0] DM_writeData;
  logic                  DM_writeEnable;
  logic                  DM_readEnable;
  logic [arm_pkg::N-1:0] DM_readData;
  logic                  stall;
  logic [arm_pkg::N-1:0] mem_addr;
  logic [arm_pkg::N-1:0] mem_writeData;
  logic                  mem_writeEnable;
  logic                  mem_readEnable;
  logic [arm_pkg::N-1:0] mem_readData;
  logic                  dump;
  logic                  mem_dump;
  logic [CW-1:0]         count;

  modport slave (
    input  DM_addr, DM_writeData, DM_writeEnable, DM_readEnable, mem_readData, dump,
    output DM_readData, stall, mem_addr, mem_writeData, mem_writeEnable, mem_readEnable,
           mem_dump, count
  );

  modport master (
    output DM_addr, DM_writeData, DM_writeEnable, DM_readEnable, mem_readData, dump,
    input  DM_readData, stall, mem_addr, mem_writeData, mem_writeEnable, mem_readEnable,
           mem_dump, count
  );
endinterface

// File: rtl/sb_match.sv
// Youngest-first tag search over the circular entry array; age 1 is the slot just behind the tail.
module sb_match #(
  parameter int DEPTH = 4,
  parameter int TW    = 61
) (
  input  logic [TW-1:0]              i_tags [DEPTH],
  input  logic [DEPTH-1:0]           i_valid,
  input  logic [$clog2(DEPTH)-1:0]   i_tail,
  input  logic [TW-1:0]              i_tag,
  output logic                       o_hit,
  output logic [$clog2(DEPTH)-1:0]   o_idx
);
  localparam int PW = $clog2(DEPTH);

  always_comb begin
    logic [PW-1:0] v_pos;
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    v_pos = '0;
    o_hit = 1'b0;
    o_idx = i_tail;
    // Oldest to youngest: the last match written wins, which is the youngest.
    for (int age = DEPTH; age >= 1; age--) begin
      v_pos = i_tail - PW'(age);
      if (i_valid[v_pos] && (i_tags[v_pos] == i_tag)) begin
        o_hit = 1'b1;
        o_idx = v_pos;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO between the core data port and dmem, with load forwarding and dump hold-off.
module store_buffer
  import arm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic           CLOCK_50,
  input logic           reset,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t       r_entries [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  sb_state_e       r_state;
  logic            r_mem_dump;

  logic [TAG_W-1:0] w_tags [DEPTH];
  logic [TAG_W-1:0] w_qtag;
  logic             w_hit;
  logic [PW-1:0]    w_idx;
  logic             w_full;
  logic             w_load_mem;
  logic             w_drain;
  logic             w_stall;
  logic             w_enq;
  logic [CW-1:0]    w_count_nxt;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_tags[i] = r_entries[i].tag;
  end

  assign w_qtag = bus.DM_addr[N-1:DW_OFFSET];

  sb_match #(.DEPTH(DEPTH), .TW(TAG_W)) u_match (
    .i_tags  (w_tags),
    .i_valid (r_valid),
    .i_tail  (r_tail),
    .i_tag   (w_qtag),
    .o_hit   (w_hit),
    .o_idx   (w_idx)
  );

  // A load that misses owns the dmem port this cycle; otherwise the head may drain.
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_load_mem  = reset && bus.DM_readEnable && !w_hit;
  assign w_drain     = (r_count != '0) && !w_load_mem;
  assign w_stall     = bus.DM_writeEnable && (w_full || (r_state == SB_FLUSH));
  assign w_enq       = bus.DM_writeEnable && !w_stall;
  assign w_count_nxt = r_count + CW'(w_enq) - CW'(w_drain);

  assign bus.stall           = w_stall;
  assign bus.mem_readEnable  = w_load_mem;
  assign bus.mem_writeEnable = w_drain;
  assign bus.mem_addr        = w_load_mem ? bus.DM_addr :
                               w_drain    ? {r_entries[r_head].tag, {DW_OFFSET{1'b0}}} : '0;
  assign bus.mem_writeData   = w_drain ? r_entries[r_head].data : '0;
  assign bus.DM_readData     = !(reset && bus.DM_readEnable) ? '0 :
                               w_hit ? r_entries[w_idx].data : bus.mem_readData;
  assign bus.mem_dump        = r_mem_dump;
  assign bus.count           = r_count;

  // NOTE: entry storage has no reset; the valid bits alone decide whether a slot is live.
  always_ff @(posedge CLOCK_50) begin
    if (w_enq) r_entries[r_tail] <= '{tag: w_qtag, data: bus.DM_writeData};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= w_count_nxt;
    end
  end

  // Dump is passed on only once the buffer will be empty after this edge.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state    <= SB_IDLE;
      r_mem_dump <= 1'b0;
    end else begin
      case (r_state)
        SB_IDLE:  if (bus.dump)  r_state <= SB_FLUSH;
        SB_FLUSH: if (!bus.dump) r_state <= SB_IDLE;
        default:  r_state <= SB_IDLE;
      endcase
      r_mem_dump <= bus.dump && (w_count_nxt == '0);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed and random stimulus for store_buffer against a queue-based model of posted stores.
module tb_store_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  st_t  q[$];
  bit   flushing = 1'b0;
  bit   watch10 = 1'b0;
  bit   saw10 = 1'b0;

  store_buffer_if #(.DEPTH(DEPTH)) sb ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (sb)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mrd(input logic [63:0] a);
    return {a[31:0], ~a[31:0]} ^ 64'h5a5a_1234_c3c3_0f0f;
  endfunction

  always_comb sb.mem_readData = mrd(sb.mem_addr);

  always @(posedge clk)
    if (watch10 && sb.mem_writeEnable && (sb.mem_addr[63:3] == 61'h2)) saw10 = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs at negedge, then registered ones.
  task automatic step(input bit wr, input bit rd, input logic [63:0] addr,
                      input logic [63:0] data, input bit dmp);
    bit          hit;
    bit          ld_mem;
    bit          drain;
    bit          stl;
    logic [63:0] fwd;
    sb.DM_writeEnable = wr;
    sb.DM_readEnable  = rd;
    sb.DM_addr        = addr;
    sb.DM_writeData   = data;
    sb.dump           = dmp;
    @(negedge clk);
    hit = 1'b0;
    fwd = '0;
    foreach (q[i]) if (q[i].addr[63:3] == addr[63:3]) begin hit = 1'b1; fwd = q[i].data; end
    ld_mem = rd && !hit;
    drain  = (q.size() > 0) && !ld_mem;
    stl    = wr && ((q.size() == DEPTH) || flushing);
    check("stall", 64'(sb.stall), 64'(stl));
    check("mem_readEnable", 64'(sb.mem_readEnable), 64'(ld_mem));
    check("mem_writeEnable", 64'(sb.mem_writeEnable), 64'(drain));
    check("DM_readData", sb.DM_readData, !rd ? 64'h0 : (hit ? fwd : mrd(addr)));
    if (ld_mem) check("mem_addr_load", sb.mem_addr, addr);
    if (drain) begin
      check("mem_addr_drain", sb.mem_addr, {q[0].addr[63:3], 3'b000});
      check("mem_writeData", sb.mem_writeData, q[0].data);
    end
    @(posedge clk);
    if (drain) void'(q.pop_front());
    if (wr && !stl) q.push_back('{addr, data});
    flushing = dmp;
    #1;
    check("count", 64'(sb.count), 64'(q.size()));
    check("mem_dump", 64'(sb.mem_dump), 64'(dmp && (q.size() == 0)));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
  endtask

  initial begin
    sb.DM_writeEnable = 1'b0;
    sb.DM_readEnable  = 1'b0;
    sb.DM_addr        = '0;
    sb.DM_writeData   = '0;
    sb.dump           = 1'b0;

    // Reset state
    #12;
    check("rst_count", 64'(sb.count), 64'h0);
    check("rst_stall", 64'(sb.stall), 64'h0);
    check("rst_mem_dump", 64'(sb.mem_dump), 64'h0);
    check("rst_mem_we", 64'(sb.mem_writeEnable), 64'h0);
    check("rst_mem_re", 64'(sb.mem_readEnable), 64'h0);
    check("rst_DM_readData", sb.DM_readData, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single store then drain on the idle cycle
    step(1'b1, 1'b0, 64'h08, 64'hAA, 1'b0);
    check("single_count1", 64'(sb.count), 64'h1);
    idle();
    check("single_count0", 64'(sb.count), 64'h0);

    // Forwarding: youngest match wins, same doubleword hits, next doubleword misses
    step(1'b1, 1'b1, 64'h40, 64'h7, 1'b0);
    step(1'b1, 1'b1, 64'h10, 64'h1, 1'b0);
    step(1'b1, 1'b1, 64'h10, 64'h2, 1'b0);
    step(1'b0, 1'b1, 64'h10, 64'h0, 1'b0);
    step(1'b0, 1'b1, 64'h14, 64'h0, 1'b0);
    step(1'b0, 1'b1, 64'h18, 64'h0, 1'b0);
    idle();

    // Fill with drains blocked by missing loads, then stall and retry
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 64'h100 + 64'(i) * 8, 64'h1000 + 64'(i), 1'b0);
    check("full_count", 64'(sb.count), 64'h4);
    step(1'b1, 1'b1, 64'h140, 64'h5555, 1'b0);
    step(1'b1, 1'b0, 64'h140, 64'h5555, 1'b0);
    step(1'b1, 1'b0, 64'h140, 64'h5555, 1'b0);
    check("retry_count", 64'(sb.count), 64'h3);
    repeat (4) idle();

    // Dump hold-off with three entries; stores stall during flush
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 64'h200 + 64'(i) * 8, 64'h2000 + 64'(i), 1'b0);
    step(1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
    step(1'b1, 1'b0, 64'h300, 64'h33, 1'b1);
    step(1'b1, 1'b0, 64'h300, 64'h33, 1'b1);
    check("dump_raised", 64'(sb.mem_dump), 64'h1);
    step(1'b1, 1'b0, 64'h300, 64'h33, 1'b1);
    step(1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    idle();

    // Wrap-around: ten stores interleaved with idle drain cycles
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 64'h400 + 64'(i) * 8, 64'hBEEF_0000 + 64'(i), 1'b0);
      if (i % 3 == 2) idle();
    end
    repeat (4) idle();

    // Reset mid-operation discards buffered stores
    step(1'b1, 1'b1, 64'h10, 64'h11, 1'b0);
    step(1'b1, 1'b1, 64'h18, 64'h12, 1'b0);
    step(1'b1, 1'b1, 64'h20, 64'h13, 1'b0);
    check("pre_reset_count", 64'(sb.count), 64'h3);
    sb.DM_writeEnable = 1'b0;
    sb.DM_readEnable  = 1'b0;
    watch10 = 1'b1;
    #1;
    rst_n = 1'b0;
    q.delete();
    flushing = 1'b0;
    #1;
    check("async_rst_count", 64'(sb.count), 64'h0);
    check("async_rst_mem_we", 64'(sb.mem_writeEnable), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) idle();
    check("no_write_0x10", 64'(saw10), 64'h0);
    watch10 = 1'b0;

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom % 3) == 0,
           64'h800 + 64'($urandom_range(0, 5)) * 8 + 64'($urandom_range(0, 7)),
           {$urandom, $urandom}, ($urandom % 12) == 0);
    end
    repeat (6) idle();
    check("final_count", 64'(sb.count), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
